// File: rtl/data_sram_responder.sv
// Responder end of the CPU data SRAM port: local word RAM plus a config window (LED, switch, timer, scratch).
// Optional macro RESP_TIMER_EN adds the free-running TIMER at offset 0x0008; without it that offset is unmapped.
module data_sram_responder #(
  parameter int unsigned RAM_AW     = 12,
  parameter logic [15:0] CONF_HI    = 16'hBFAF,
  parameter logic [31:0] TIMER_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  localparam int unsigned DEPTH = 1 << RAM_AW;

  localparam logic [13:0] OFF_LED      = 14'h0;
  localparam logic [13:0] OFF_SWITCH   = 14'h1;
  localparam logic [13:0] OFF_TIMER    = 14'h2;
  localparam logic [13:0] OFF_SCRATCH0 = 14'h3;
  localparam logic [13:0] OFF_SCRATCH1 = 14'h4;

  logic [31:0] mem [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q;
  logic [31:0] scratch0_q, scratch1_q;
  logic [15:0] sync1_q, sync2_q;
  logic [31:0] conf_rdata;

  logic              is_conf, do_wr, do_rd, conf_wr, ram_wr;
  logic [13:0]       off;
  logic [RAM_AW-1:0] idx;
  logic              unused_addr_lsb;

  assign is_conf = (data_sram_addr[31:16] == CONF_HI);
  assign off     = data_sram_addr[15:2];
  assign idx     = data_sram_addr[RAM_AW+1:2];
  assign do_wr   = data_sram_en && (data_sram_wen != 4'b0000);
  assign do_rd   = data_sram_en && (data_sram_wen == 4'b0000);
  assign conf_wr = do_wr && is_conf;
  assign ram_wr  = do_wr && !is_conf;
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  // Byte-enable merge shared by every writable config register.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // RAM contents are deliberately not reset so they survive a CPU reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

`ifdef RESP_TIMER_EN
  logic [31:0] timer_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= TIMER_INIT;
    end else if (conf_wr && off == OFF_TIMER) begin
      timer_q <= merge(timer_q, data_sram_wdata, data_sram_wen);
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`endif

  always_comb begin
    conf_rdata = 32'h0;
    case (off)
      OFF_LED:      conf_rdata = {16'h0, led_q};
      OFF_SWITCH:   conf_rdata = {16'h0, sync2_q};
`ifdef RESP_TIMER_EN
      OFF_TIMER:    conf_rdata = timer_q;
`endif
      OFF_SCRATCH0: conf_rdata = scratch0_q;
      OFF_SCRATCH1: conf_rdata = scratch1_q;
      default:      conf_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (do_rd) rdata_d = is_conf ? conf_rdata : mem[idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q    <= 32'h0;
      led_q      <= 16'h0;
      scratch0_q <= 32'h0;
      scratch1_q <= 32'h0;
      sync1_q    <= 16'h0;
      sync2_q    <= 16'h0;
    end else begin
      rdata_q <= rdata_d;
      sync1_q <= switch_in;
      sync2_q <= sync1_q;
      if (conf_wr) begin
        case (off)
          OFF_LED:      led_q      <= merge({16'h0, led_q}, data_sram_wdata, data_sram_wen) & 32'h0000FFFF;
          OFF_SCRATCH0: scratch0_q <= merge(scratch0_q, data_sram_wdata, data_sram_wen);
          OFF_SCRATCH1: scratch1_q <= merge(scratch1_q, data_sram_wdata, data_sram_wen);
          default:      ;
        endcase
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: table of single-cycle requests plus hand-written
// sequences for switch synchronisation, async reset during a read, and timer behaviour.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic [15:0] exp_led, input string name);
    vec_t v;
    v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_led = exp_led; v.name = name;
    vecs.push_back(v);
  endtask

  // One request cycle: drive at negedge, sample 1 time unit after the following posedge.
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] timer_a, timer_b;

  initial begin
`ifdef RESP_TIMER_EN
    timer_a = 32'hFFFFFFFE;
    timer_b = 32'h00000000;
`else
    timer_a = 32'h0;
    timer_b = 32'h0;
`endif
    add(1, 4'h0, 32'hBFAF000C, 32'h0,        32'h00000000, 16'h0000, "rd_scratch0_reset");
    add(1, 4'hF, 32'h00001000, 32'hAABBCCDD, 32'h00000000, 16'h0000, "wr_ram_full");
    add(1, 4'h5, 32'h00001000, 32'h11223344, 32'h00000000, 16'h0000, "wr_ram_bytes");
    add(1, 4'h0, 32'h00001000, 32'h0,        32'hAA22CC44, 16'h0000, "rd_ram_merged");
    add(1, 4'hF, 32'h00004010, 32'h00000005, 32'hAA22CC44, 16'h0000, "wr_hold_rdata");
    add(1, 4'h0, 32'h00000010, 32'h0,        32'h00000005, 16'h0000, "rd_alias");
    add(0, 4'h0, 32'h00000000, 32'h0,        32'h00000005, 16'h0000, "idle_hold1");
    add(0, 4'h0, 32'h00000000, 32'h0,        32'h00000005, 16'h0000, "idle_hold2");
    add(0, 4'h0, 32'h00000000, 32'h0,        32'h00000005, 16'h0000, "idle_hold3");
    add(1, 4'hF, 32'hBFAF0000, 32'h1234ABCD, 32'h00000005, 16'hABCD, "wr_led");
    add(1, 4'h0, 32'hBFAF0000, 32'h0,        32'h0000ABCD, 16'hABCD, "rd_led");
    add(1, 4'h2, 32'hBFAF0000, 32'h00005500, 32'h0000ABCD, 16'h55CD, "wr_led_byte1");
    add(1, 4'h0, 32'hBFAF0000, 32'h0,        32'h000055CD, 16'h55CD, "rd_led_byte1");
    add(1, 4'hF, 32'hBFAF0020, 32'hFFFFFFFF, 32'h000055CD, 16'h55CD, "wr_unmapped");
    add(1, 4'h0, 32'hBFAF0020, 32'h0,        32'h00000000, 16'h55CD, "rd_unmapped");
    add(1, 4'hF, 32'hBFAF0010, 32'hCAFEBABE, 32'h00000000, 16'h55CD, "wr_scratch1");
    add(1, 4'h8, 32'hBFAF0010, 32'h11000000, 32'h00000000, 16'h55CD, "wr_scratch1_b3");
    add(1, 4'h0, 32'hBFAF0010, 32'h0,        32'h11FEBABE, 16'h55CD, "rd_scratch1");
    add(1, 4'hF, 32'hBFAF000C, 32'h00000077, 32'h11FEBABE, 16'h55CD, "wr_scratch0");
    add(1, 4'h0, 32'hBFAF000C, 32'h0,        32'h00000077, 16'h55CD, "rd_scratch0");
    add(1, 4'h0, 32'h00001000, 32'h0,        32'hAA22CC44, 16'h55CD, "rd_b2b_first");
    add(1, 4'h0, 32'h00000010, 32'h0,        32'h00000005, 16'h55CD, "rd_b2b_second");
    add(1, 4'hF, 32'h00002000, 32'hDEADBEEF, 32'h00000005, 16'h55CD, "wr_raw");
    add(1, 4'h0, 32'h00002000, 32'h0,        32'hDEADBEEF, 16'h55CD, "rd_after_wr");
    add(1, 4'hF, 32'hBFAF0008, 32'hFFFFFFFE, 32'hDEADBEEF, 16'h55CD, "wr_timer");
    add(1, 4'h0, 32'hBFAF0008, 32'h0,        timer_a,      16'h55CD, "rd_timer_next");
    add(0, 4'h0, 32'h00000000, 32'h0,        timer_a,      16'h55CD, "timer_idle_hold");
    add(1, 4'h0, 32'hBFAF0008, 32'h0,        timer_b,      16'h55CD, "rd_timer_wrap");
    add(1, 4'h0, 32'hBFAF000C, 32'h0,        32'h00000077, 16'h55CD, "rd_scratch0_again");

    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in       = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, "_rdata"}, data_sram_rdata, vecs[i].exp_rd);
      check({vecs[i].name, "_led"}, {16'h0, led_out}, {16'h0, vecs[i].exp_led});
    end

    // Switch change is not visible in the same cycle; it is after the synchroniser settles.
    switch_in = 16'h00F0;
    drive(1, 4'h0, 32'hBFAF0004, 32'h0);
    check("switch_not_yet", data_sram_rdata, 32'h0);
    repeat (3) drive(0, 4'h0, 32'h0, 32'h0);
    drive(1, 4'h0, 32'hBFAF0004, 32'h0);
    check("switch_visible", data_sram_rdata, 32'h000000F0);

    // Async reset between the read request and its edge aborts the read.
    @(negedge clk);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = 32'hBFAF000C;
    #2 resetn = 1'b0;
    #1;
    check("reset_async_rdata", data_sram_rdata, 32'h0);
    check("reset_async_led", {16'h0, led_out}, 32'h0);
    @(posedge clk);
    #1;
    check("reset_abort_rdata", data_sram_rdata, 32'h0);
    data_sram_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 4'h0, 32'hBFAF000C, 32'h0);
    check("scratch0_cleared", data_sram_rdata, 32'h0);
    drive(1, 4'h0, 32'h00001000, 32'h0);
    check("ram_retained", data_sram_rdata, 32'hAA22CC44);
    drive(1, 4'h0, 32'hBFAF0008, 32'h0);
`ifdef RESP_TIMER_EN
    check("timer_after_reset", data_sram_rdata, 32'h00000002);
`else
    check("timer_absent", data_sram_rdata, 32'h0);
`endif
    drive(0, 4'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
